// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the external memory bus arbiter.
package mem_bus_arbiter_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE    = 3'd0,
    ARB_D_BUS   = 3'd1,
    ARB_I_BUS   = 3'd2,
    ARB_I_DRAIN = 3'd3,
    ARB_D_DONE  = 3'd4,
    ARB_I_DONE  = 3'd5
  } arb_state_e;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
  localparam logic [3:0]  SEL_ALL   = 4'hF;
  localparam int          TMO_W     = 16;

  typedef struct packed {
    logic        cyc;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Single-master bus arbiter: data port has priority over instruction fetch;
// registered bus cycle, ack-or-timeout completion, combinational stall requests.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_stallreq_o,
  input  logic        dm_req_i,
  input  logic        dm_we_i,
  input  logic [3:0]  dm_sel_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  output logic [31:0] dm_rdata_o,
  output logic        dm_stallreq_o,
  output logic        bus_cyc_o,
  output logic        bus_stb_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  output logic        bus_err_o
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  arb_state_e       state_q, state_d;
  bus_req_t         bus_q, bus_d;
  logic [31:0]      if_rdata_q, if_rdata_d;
  logic [31:0]      dm_rdata_q, dm_rdata_d;
  logic             err_q, err_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             tmo_hit;

  // Abort only when this would be the TIMEOUT-th bus cycle and no ack arrives in it.
  assign tmo_hit = (TIMEOUT != 0) && (tmo_q == TMO_LAST) && !bus_ack_i;

  always_comb begin
    state_d    = state_q;
    bus_d      = bus_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    err_d      = 1'b0;
    tmo_d      = tmo_q + TMO_W'(1);
    case (state_q)
      ARB_IDLE: begin
        tmo_d = '0;
        if (dm_req_i) begin
          bus_d   = '{cyc: 1'b1, we: dm_we_i, sel: dm_sel_i, addr: dm_addr_i, wdata: dm_wdata_i};
          state_d = ARB_D_BUS;
        end else if (if_req_i) begin
          bus_d   = '{cyc: 1'b1, we: 1'b0, sel: SEL_ALL, addr: if_addr_i, wdata: ZERO_WORD};
          state_d = ARB_I_BUS;
        end
      end
      ARB_D_BUS: begin
        if (bus_ack_i) begin
          dm_rdata_d = bus_rdata_i;
          bus_d.cyc  = 1'b0;
          state_d    = ARB_D_DONE;
        end else if (tmo_hit) begin
          dm_rdata_d = ZERO_WORD;
          bus_d.cyc  = 1'b0;
          err_d      = 1'b1;
          state_d    = ARB_D_DONE;
        end
      end
      ARB_I_BUS: begin
        if (bus_ack_i || tmo_hit) begin
          bus_d.cyc = 1'b0;
          err_d     = tmo_hit;
          // A flush in the completing cycle cancels delivery either way.
          if (flush) begin
            state_d = ARB_IDLE;
          end else begin
            if_rdata_d = bus_ack_i ? bus_rdata_i : ZERO_WORD;
            state_d    = ARB_I_DONE;
          end
        end else if (flush) begin
          tmo_d   = '0;
          state_d = ARB_I_DRAIN;
        end
      end
      ARB_I_DRAIN: begin
        if (bus_ack_i || tmo_hit) begin
          bus_d.cyc = 1'b0;
          err_d     = tmo_hit;
          state_d   = ARB_IDLE;
        end
      end
      ARB_D_DONE, ARB_I_DONE: state_d = ARB_IDLE;
      default:                state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ARB_IDLE;
      bus_q      <= '0;
      if_rdata_q <= ZERO_WORD;
      dm_rdata_q <= ZERO_WORD;
      err_q      <= 1'b0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      bus_q      <= bus_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      err_q      <= err_d;
      tmo_q      <= tmo_d;
    end
  end

  assign bus_cyc_o     = bus_q.cyc;
  assign bus_stb_o     = bus_q.cyc;
  assign bus_we_o      = bus_q.we;
  assign bus_sel_o     = bus_q.sel;
  assign bus_addr_o    = bus_q.addr;
  assign bus_wdata_o   = bus_q.wdata;
  assign bus_err_o     = err_q;
  assign if_rdata_o    = if_rdata_q;
  assign dm_rdata_o    = dm_rdata_q;
  assign dm_stallreq_o = dm_req_i && (state_q != ARB_D_DONE);
  assign if_stallreq_o = if_req_i && (state_q != ARB_I_DONE);

endmodule
